// File: rtl/jelly_img_to_axi4s_fifo_pkg.sv
// ---------------------------------------------------------------------------
// jelly_img_to_axi4s_fifo_pkg
// Shared types and helpers for the img -> AXI4-Stream sink with FIFO.
//   fifo_word_t : FIFO word layout {user, frame_start, last, data} at the
//                 default widths. The top module declares the same layout
//                 at its own parameter widths.
//   fifo_depth  : number of FIFO words for a given pointer width.
//   word_width  : packed FIFO word width for given user/data widths.
// ---------------------------------------------------------------------------
package jelly_img_to_axi4s_fifo_pkg;

  localparam int DEF_USER_WIDTH     = 1;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_FIFO_PTR_WIDTH = 5;
  localparam int DEPTH              = 2 ** DEF_FIFO_PTR_WIDTH;

  typedef struct packed {
    logic [DEF_USER_WIDTH-1:0] user;
    logic                      frame_start;
    logic                      last;
    logic [DEF_DATA_WIDTH-1:0] data;
  } fifo_word_t;

  function automatic int fifo_depth(input int ptr_w);
    return 1 << ptr_w;
  endfunction

  function automatic int word_width(input int user_w, input int data_w);
    return user_w + 2 + data_w;
  endfunction

endpackage

// File: rtl/jelly_img_to_axi4s_fifo_if.sv
// ---------------------------------------------------------------------------
// jelly_img_to_axi4s_fifo_if
// AXI4-Stream bus carried out of the img sink.
//   tuser  : {img user, frame_start}
//   tlast  : line end
//   tdata  : pixel
//   tvalid : beat valid (master drives)
//   tready : beat ready (slave drives)
// ---------------------------------------------------------------------------
interface jelly_img_to_axi4s_fifo_if
  import jelly_img_to_axi4s_fifo_pkg::*;
#(
  parameter int USER_WIDTH = DEF_USER_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [USER_WIDTH:0]   tuser;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tuser, output tlast, output tdata, output tvalid, input tready);
  modport slave  (input tuser, input tlast, input tdata, input tvalid, output tready);

endinterface

// File: rtl/jelly_img_to_axi4s_fifo_ram.sv
// ---------------------------------------------------------------------------
// jelly_img_to_axi4s_fifo_ram
// Simple dual-port RAM: synchronous write, registered read with read enable.
// The read register doubles as the FWFT output register of the FIFO, so it
// is reset to zero and holds its value while rd_en_i is low.
//   clk, reset          : clock, synchronous active-high reset (read reg only)
//   wr_en_i/addr/data   : write port
//   rd_en_i/rd_addr_i   : read port, data appears on rd_data_o next cycle
//   RAM_TYPE            : "block" or anything else (distributed) style hint
// ---------------------------------------------------------------------------
module jelly_img_to_axi4s_fifo_ram
  import jelly_img_to_axi4s_fifo_pkg::*;
#(
  parameter int    ADDR_WIDTH = 5,
  parameter int    DATA_WIDTH = 8,
  parameter string RAM_TYPE   = "distributed"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int WORDS = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] rd_data_q;

  generate
    if (RAM_TYPE == "block") begin : g_block
      (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [WORDS];

      always_ff @(posedge clk) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
      end

      always_ff @(posedge clk) begin
        if (reset)        rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
      end
    end else begin : g_dist
      (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [WORDS];

      always_ff @(posedge clk) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
      end

      always_ff @(posedge clk) begin
        if (reset)        rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
      end
    end
  endgenerate

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/jelly_img_to_axi4s_fifo.sv
// ---------------------------------------------------------------------------
// jelly_img_to_axi4s_fifo
// Sink end of the img stream: turns cke-qualified img beats into an
// AXI4-Stream master (tuser[0] = frame start, tlast = line end) through a
// FIFO, and throttles the upstream pipeline via img_cke.
//   clk, reset          : clock, synchronous active-high reset
//   img_cke             : registered clock enable for upstream img pipeline
//   s_img_*             : img input beat (only valid & de beats are stored)
//   m_axi4s             : AXI4-Stream master (interface, modport master)
//   overflow            : sticky, write attempted while FIFO full
//   frame_error         : sticky pixel_first/pixel_last sequencing error,
//                         present only with JELLY_IMG_TO_AXI4S_FIFO_FRAME_CHECK_EN
// The RAM read register is the FWFT output register; it is not counted in
// count_q, so up to DEPTH+1 words can be held in total.
// ---------------------------------------------------------------------------
module jelly_img_to_axi4s_fifo
  import jelly_img_to_axi4s_fifo_pkg::*;
#(
  parameter int    USER_WIDTH     = 1,
  parameter int    DATA_WIDTH     = 8,
  parameter int    FIFO_PTR_WIDTH = 5,
  parameter int    CKE_MARGIN     = 2,
  parameter string RAM_TYPE       = "distributed"
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      img_cke,
  input  logic                      s_img_line_first,
  input  logic                      s_img_line_last,
  input  logic                      s_img_pixel_first,
  input  logic                      s_img_pixel_last,
  input  logic                      s_img_de,
  input  logic [USER_WIDTH-1:0]     s_img_user,
  input  logic [DATA_WIDTH-1:0]     s_img_data,
  input  logic                      s_img_valid,
  jelly_img_to_axi4s_fifo_if.master m_axi4s,
`ifdef JELLY_IMG_TO_AXI4S_FIFO_FRAME_CHECK_EN
  output logic                      frame_error,
`endif
  output logic                      overflow
);

  localparam int FIFO_DEPTH = fifo_depth(FIFO_PTR_WIDTH);
  localparam int CNT_W      = FIFO_PTR_WIDTH + 1;
  localparam int WORD_W     = word_width(USER_WIDTH, DATA_WIDTH);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(CKE_MARGIN);

  typedef struct packed {
    logic [USER_WIDTH-1:0] user;
    logic                  frame_start;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  logic                      cke_q, cke_d;
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      vld_q, vld_d;
  logic                      overflow_q, overflow_d;

  logic  wr_en, full, ram_we, rd_en;
  word_t wr_word, rd_word;

  // line_last carries no information the AXI4-Stream side needs
  logic unused_line_last;
  assign unused_line_last = s_img_line_last;

  assign wr_en  = cke_q & s_img_valid & s_img_de;
  assign full   = (count_q == DEPTH_C);
  assign ram_we = wr_en & ~full;
  // Refill the output register whenever it is empty or being consumed
  assign rd_en  = (count_q != '0) & (~vld_q | m_axi4s.tready);

  assign wr_word.user        = s_img_user;
  assign wr_word.frame_start = s_img_line_first & s_img_pixel_first;
  assign wr_word.last        = s_img_pixel_last;
  assign wr_word.data        = s_img_data;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + FIFO_PTR_WIDTH'(ram_we);
    rd_ptr_d   = rd_ptr_q + FIFO_PTR_WIDTH'(rd_en);
    count_d    = count_q + CNT_W'(ram_we) - CNT_W'(rd_en);
    // Free slots are judged on the post-update count so cke reacts in time
    cke_d      = (DEPTH_C - count_d) > MARGIN_C;
    vld_d      = rd_en | (vld_q & ~m_axi4s.tready);
    overflow_d = overflow_q | (wr_en & full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cke_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      vld_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cke_q      <= cke_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      vld_q      <= vld_d;
      overflow_q <= overflow_d;
    end
  end

  jelly_img_to_axi4s_fifo_ram #(
    .ADDR_WIDTH (FIFO_PTR_WIDTH),
    .DATA_WIDTH (WORD_W),
    .RAM_TYPE   (RAM_TYPE)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_word),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_word)
  );

  assign m_axi4s.tuser  = {rd_word.user, rd_word.frame_start};
  assign m_axi4s.tlast  = rd_word.last;
  assign m_axi4s.tdata  = rd_word.data;
  assign m_axi4s.tvalid = vld_q;

  assign img_cke  = cke_q;
  assign overflow = overflow_q;

`ifdef JELLY_IMG_TO_AXI4S_FIFO_FRAME_CHECK_EN
  logic frame_error_q, prev_last_q, seen_q;

  // pixel_first must follow exactly the beats that ended a line
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_error_q <= 1'b0;
      prev_last_q   <= 1'b0;
      seen_q        <= 1'b0;
    end else if (wr_en) begin
      seen_q      <= 1'b1;
      prev_last_q <= s_img_pixel_last;
      if (seen_q && (s_img_pixel_first != prev_last_q)) frame_error_q <= 1'b1;
    end
  end

  assign frame_error = frame_error_q;
`endif

endmodule
